// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types, default width and counter sizing for the multiplier sequencer
package mult_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int WIDTH_DEFAULT = 4;

    // Counter must hold the value WIDTH itself, hence width+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_iter_cnt.sv
// rtl/mult_seq_ctrl_iter_cnt.sv - iteration down-counter for the multiplier sequencer
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load counter with WIDTH
//   dec         decrement by one (saturates at zero, never wraps)
//   cnt         current count
//   is_one      count equals one (last iteration)
module iter_cnt
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(WIDTH);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - Moore sequencer for the 4-bit shift-add multiplier datapath
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       operation request, sampled only in IDLE
//   q0          LSB of multiplier register Q
//   c1          load M from ia (LOAD only)
//   c_ldq       load multiplier register Q
//   c_clr       clear accumulator A
//   c_add       A <= A + M
//   c_shr       shift {A,Q} right one bit
//   busy        high in every state except IDLE
//   done        one-cycle pulse, product valid in {A,Q}
//   abort       (ABORT_EN only) abandon a running operation
//   aborted     (ABORT_EN only) one-cycle pulse after an accepted abort
//
// Build option: define ABORT_EN to add the abort/aborted ports.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic q0,
`ifdef ABORT_EN
    input  logic abort,
    output logic aborted,
`endif
    output logic c1,
    output logic c_ldq,
    output logic c_clr,
    output logic c_add,
    output logic c_shr,
    output logic busy,
    output logic done
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_is_one;

    iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == LOAD),
        .dec    (state_q == SHIFT),
        .cnt    (cnt),
        .is_one (cnt_is_one)
    );

`ifdef ABORT_EN
    logic aborted_q;
    logic aborted_d;
`endif

    // Strobes depend only on state_q, so they never follow start/q0/abort combinationally.
    always_comb begin
        state_d = state_q;
        c1      = 1'b0;
        c_ldq   = 1'b0;
        c_clr   = 1'b0;
        c_add   = 1'b0;
        c_shr   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                c1      = 1'b1;
                c_ldq   = 1'b1;
                c_clr   = 1'b1;
                state_d = TEST;
            end
            TEST: begin
                state_d = q0 ? ADD : SHIFT;
            end
            ADD: begin
                c_add   = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                c_shr   = 1'b1;
                state_d = cnt_is_one ? DONE : TEST;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
`ifdef ABORT_EN
        aborted_d = 1'b0;
        if (abort && (state_q inside {LOAD, TEST, ADD, SHIFT})) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`endif

    // The loop exits at cnt==1, so an iterating state must never see zero.
    a_cnt_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q inside {TEST, ADD, SHIFT}) |-> (cnt != '0));

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - directed self-checking bench for mult_seq_ctrl with a shift-add datapath model
module tb_mult_seq_ctrl;

    localparam int W = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       q0;
    logic       c1, c_ldq, c_clr, c_add, c_shr, busy, done;
`ifdef ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    logic [3:0] ia  = 4'h0;
    logic [3:0] qin = 4'h0;
    logic [3:0] m_r = 4'h0;
    logic [3:0] q_r = 4'h0;
    logic [4:0] a_r = 5'h0;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_viol = 0;
    int n_done = 0;

    int trace [0:31];
    int tr_len;
    int exp_tr [0:12] = '{1, 2, 3, 4, 2, 3, 4, 2, 4, 2, 3, 4, 5};

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .q0      (q0),
`ifdef ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .c1      (c1),
        .c_ldq   (c_ldq),
        .c_clr   (c_clr),
        .c_add   (c_add),
        .c_shr   (c_shr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Datapath: M register, Q register, accumulator A with carry bit.
    assign q0 = q_r[0];
    always @(posedge clk) begin
        if (c1)    m_r <= ia;
        if (c_ldq) q_r <= qin;
        if (c_clr)      a_r <= 5'h0;
        else if (c_add) a_r <= a_r + {1'b0, m_r};
        else if (c_shr) {a_r, q_r} <= {a_r, q_r} >> 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (c1 && (c_add || c_shr)) n_viol++;
            if (c1 != (c_ldq && c_clr)) n_viol++;
            if (done) n_done++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {c1, c_ldq, c_clr, c_add, c_shr, busy, done};
    endfunction

    // 0 idle, 1 load, 2 test, 3 add, 4 shift, 5 done, 7 illegal combination
    function automatic int classify();
        case (outs())
            7'b0000000: return 0;
            7'b1110010: return 1;
            7'b0000010: return 2;
            7'b0001010: return 3;
            7'b0000110: return 4;
            7'b0000011: return 5;
            default:    return 7;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] m, input logic [3:0] q, output int cyc,
                          output logic [7:0] prod, output int adds, output int shrs);
        cyc = 0; prod = 8'h0; adds = 0; shrs = 0; tr_len = 0;
        @(negedge clk);
        ia = m; qin = q; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (tr_len < 32) begin
                trace[tr_len] = classify();
                tr_len++;
            end
            if (c_add) adds++;
            if (c_shr) shrs++;
            if (done) begin
                cyc  = n;
                prod = {a_r[3:0], q_r};
                break;
            end
            @(posedge clk);
        end
        if (cyc == 0) check_eq("op_timeout", 0, 1);
    endtask

    initial begin
        int         cyc, adds, shrs, dn, c1n, last_done, d0, idle_bad;
        logic [7:0] prod;
        logic       prev_done;

        // Reset state
        #2 check_eq("reset_outs", {25'h0, outs()}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); check_eq("idle_outs", {25'h0, outs()}, 0);

        // Reset in the middle of ADD
        @(negedge clk); qin = 4'hF; ia = 4'h1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (c_add) break;
        end
        check_eq("saw_add", {31'h0, c_add}, 1);
        #1 rst_n = 1'b0;
        #1 check_eq("midop_reset_outs", {25'h0, outs()}, 0);
        @(negedge clk); rst_n = 1'b1;
        idle_bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (busy || done) idle_bad++;
        end
        check_eq("post_reset_idle", idle_bad, 0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); check_eq("reset_then_load", classify(), 1);
        for (int n = 0; n < 30 && !done; n++) @(negedge clk);
        check_eq("reset_then_done", {31'h0, done}, 1);

        // Multiplier 0xB, M = 0x5
        run_op(4'h5, 4'hB, cyc, prod, adds, shrs);
        check_eq("b_len", tr_len, 13);
        for (int i = 0; i < 13; i++) check_eq($sformatf("b_trace%0d", i), trace[i], exp_tr[i]);
        check_eq("b_latency", cyc, 13);
        check_eq("b_product", {24'h0, prod}, 32'h37);

        // Multiplier 0x0
        run_op(4'h9, 4'h0, cyc, prod, adds, shrs);
        check_eq("z_adds", adds, 0);
        check_eq("z_shrs", shrs, 4);
        check_eq("z_latency", cyc, 10);
        check_eq("z_product", {24'h0, prod}, 0);

        // Multiplier 0xF: longest path
        run_op(4'hF, 4'hF, cyc, prod, adds, shrs);
        check_eq("f_latency", cyc, 14);
        check_eq("f_product", {24'h0, prod}, 32'hE1);

        // start held high across three operations
        @(negedge clk); ia = 4'h3; qin = 4'h6; start = 1'b1;
        dn = 0; c1n = 0; last_done = 0; prev_done = 1'b0;
        for (int n = 0; n < 80 && dn < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (prev_done) check_eq("b2b_idle", {31'h0, busy}, 0);
            if (c1) begin
                c1n++;
                if (dn > 0) check_eq("b2b_gap", n - last_done, 2);
            end
            prev_done = done;
            if (done) begin
                dn++;
                last_done = n;
                check_eq("b2b_product", {24'h0, a_r[3:0], q_r}, 32'h12);
            end
        end
        start = 1'b0;
        check_eq("b2b_done_count", dn, 3);
        check_eq("b2b_c1_count", c1n, 3);

        // Exhaustive operand sweep
        n_viol = 0;
        d0 = n_done;
        for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
                run_op(m[3:0], q[3:0], cyc, prod, adds, shrs);
                check_eq($sformatf("sweep_prod_%0d_%0d", m, q), {24'h0, prod}, m * q);
                check_eq($sformatf("sweep_lat_%0d_%0d", m, q), cyc, 2 * W + $countones(q[3:0]) + 2);
            end
        end
        check_eq("sweep_c1_exclusive", n_viol, 0);
        check_eq("sweep_done_count", n_done - d0, 256);

`ifdef ABORT_EN
        // Abort during the second SHIFT, then a normal operation
        @(negedge clk); ia = 4'h2; qin = 4'hF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        shrs = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (c_shr) shrs++;
            if (shrs == 2) break;
        end
        check_eq("abort_second_shift", shrs, 2);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check_eq("abort_outs", {24'h0, aborted, outs()}, 32'h80);
        d0 = n_done;
        for (int n = 0; n < 4; n++) @(negedge clk);
        check_eq("abort_no_done", n_done - d0, 0);
        check_eq("abort_pulse_len", {31'h0, aborted}, 0);
        run_op(4'h2, 4'hF, cyc, prod, adds, shrs);
        check_eq("abort_then_product", {24'h0, prod}, 32'h1E);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
